// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: mult/div tracker state encodings and register helpers.
package mips_defs;

    localparam int unsigned REG_W = 5;
    localparam int unsigned MD_STATE_W = 2;

    localparam logic [MD_STATE_W-1:0] MD_IDLE = 2'd0;
    localparam logic [MD_STATE_W-1:0] MD_BUSY = 2'd1;
    localparam logic [MD_STATE_W-1:0] MD_DONE = 2'd2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // A source register depends on a writer only if it is a real (non-$0) match.
    function automatic logic regHit(input logic [REG_W-1:0] r, input logic [REG_W-1:0] w);
        return (r != REG_ZERO) && (r == w);
    endfunction

endpackage

// File: rtl/md_tracker.sv
// Mult/div busy tracker: IDLE -> BUSY (counted) -> DONE, HI/LO valid once back in IDLE.
module md_tracker
    import mips_defs::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic clk,
    input  logic rstn,
    input  logic mdstartE,
    output logic mdbusy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

    logic [MD_STATE_W-1:0] state;
    logic [MD_STATE_W-1:0] stateNext;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cntNext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // A start arriving in BUSY is dropped; the decode stall should make it impossible.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            MD_IDLE, MD_DONE: begin
                stateNext = MD_IDLE;
                if (mdstartE) begin
                    stateNext = MD_BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    stateNext = MD_DONE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = MD_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign mdbusy = (state != MD_IDLE);

    mdStartInBusy: assert property (@(posedge clk) disable iff (!rstn)
        !(mdstartE && (state == MD_BUSY)))
        else $error("mdstartE issued while mult/div unit busy");

endmodule

// File: rtl/hazard_stall.sv
// Decode-side hazard unit: load-use / branch-compare stalls, decode forwards, mult/div stalls.
module hazard_stall
    import mips_defs::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic             branchD,
    input  logic             hiloreadD,
    input  logic             mdstartD,
    input  logic [REG_W-1:0] writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic             mdstartE,
    input  logic [REG_W-1:0] writeregM,
    input  logic             regwriteM,
    input  logic             memtoregM,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             mdbusy
);

    logic hitE;
    logic hitM;
    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stallAny;

    assign hitE = regHit(rsD, writeregE) | regHit(rtD, writeregE);
    assign hitM = regHit(rsD, writeregM) | regHit(rtD, writeregM);

    assign lwstall = memtoregE & regwriteE & hitE;
    // Branch compares in decode: an ALU result still in E, or a load in M, is not yet forwardable.
    assign brstall = branchD & ((regwriteE & hitE) | (memtoregM & hitM));
    assign mdstall = (hiloreadD | mdstartD) & mdbusy;

    assign stallAny = lwstall | brstall | mdstall;
    assign stallF   = stallAny;
    assign stallD   = stallAny;
    assign flushE   = stallAny;

    assign forwardAD = regwriteM & ~memtoregM & regHit(rsD, writeregM);
    assign forwardBD = regwriteM & ~memtoregM & regHit(rtD, writeregM);

    md_tracker #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) uMdTracker (
        .clk      (clk),
        .rstn     (rstn),
        .mdstartE (mdstartE),
        .mdbusy   (mdbusy)
    );

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboard bench for hazard_stall with a cycle-count model of the mult/div unit.
module tb_hazard_stall;

    localparam int unsigned MD_LAT = 4;

    typedef struct packed {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic       branchD;
        logic       hiloreadD;
        logic       mdstartD;
        logic [4:0] writeregE;
        logic       regwriteE;
        logic       memtoregE;
        logic       mdstartE;
        logic [4:0] writeregM;
        logic       regwriteM;
        logic       memtoregM;
    } stim_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] rsD, rtD, writeregE, writeregM;
    logic       branchD, hiloreadD, mdstartD;
    logic       regwriteE, memtoregE, mdstartE, regwriteM, memtoregM;
    logic       stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;

    int errCnt = 0;
    int chkCnt = 0;
    int remain = 0;
    logic [5:0] expQ[$];

    hazard_stall #(.MD_LAT(MD_LAT), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .hiloreadD(hiloreadD), .mdstartD(mdstartD),
        .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE), .mdstartE(mdstartE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .mdbusy(mdbusy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [5:0] act, input logic [5:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got {sF,sD,fE,fAD,fBD,busy}=%b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic h(input logic [4:0] r, input logic [4:0] w);
        return (r != 5'd0) && (r == w);
    endfunction

    function automatic logic [5:0] refOut(input stim_t s, input logic busy);
        logic st;
        logic fa;
        logic fb;
        st = (s.memtoregE && s.regwriteE && (h(s.rsD, s.writeregE) || h(s.rtD, s.writeregE)))
          || (s.branchD && ((s.regwriteE && (h(s.rsD, s.writeregE) || h(s.rtD, s.writeregE)))
                         || (s.memtoregM && (h(s.rsD, s.writeregM) || h(s.rtD, s.writeregM)))))
          || ((s.hiloreadD || s.mdstartD) && busy);
        fa = s.regwriteM && !s.memtoregM && h(s.rsD, s.writeregM);
        fb = s.regwriteM && !s.memtoregM && h(s.rtD, s.writeregM);
        return {st, st, st, fa, fb, busy};
    endfunction

    task automatic apply(input stim_t s);
        rsD = s.rsD; rtD = s.rtD; branchD = s.branchD; hiloreadD = s.hiloreadD;
        mdstartD = s.mdstartD; writeregE = s.writeregE; regwriteE = s.regwriteE;
        memtoregE = s.memtoregE; mdstartE = s.mdstartE; writeregM = s.writeregM;
        regwriteM = s.regwriteM; memtoregM = s.memtoregM;
    endtask

    function automatic logic [5:0] dutOut();
        return {stallF, stallD, flushE, forwardAD, forwardBD, mdbusy};
    endfunction

    // One pipeline cycle: drive after negedge, score mid-low-phase, advance model at posedge.
    task automatic runCycle(input stim_t s, input string tag);
        @(negedge clk);
        apply(s);
        #1;
        expQ.push_back(refOut(s, remain > 0));
        checkVal(tag, dutOut(), expQ.pop_front());
        @(posedge clk);
        if (s.mdstartE && remain <= 1) remain = MD_LAT;
        else if (remain > 0) remain--;
    endtask

    stim_t z;
    stim_t s;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        z = '0;
        apply(z);
        rstn = 1'b0;
        #12;
        checkVal("reset", dutOut(), 6'b000000);
        @(negedge clk);
        rstn = 1'b1;

        // load-use
        s = z; s.memtoregE = 1; s.regwriteE = 1; s.writeregE = 5'd8; s.rsD = 5'd8;
        runCycle(s, "lwuse_rs");
        s.rsD = 5'd3; s.rtD = 5'd8;
        runCycle(s, "lwuse_rt");
        s = z; s.memtoregE = 1; s.regwriteE = 1;
        runCycle(s, "lwuse_r0");
        runCycle(z, "quiet");

        // branch compare
        s = z; s.branchD = 1; s.rsD = 5'd5; s.regwriteE = 1; s.writeregE = 5'd5;
        runCycle(s, "br_E");
        s = z; s.branchD = 1; s.rsD = 5'd5; s.regwriteM = 1; s.writeregM = 5'd5;
        runCycle(s, "br_fwdA");
        s.memtoregM = 1;
        runCycle(s, "br_loadM");
        s = z; s.branchD = 1; s.rtD = 5'd9; s.regwriteM = 1; s.writeregM = 5'd9;
        runCycle(s, "br_fwdB");
        s = z; s.regwriteM = 1; s.rsD = 5'd7; s.rtD = 5'd7; s.writeregM = 5'd7;
        runCycle(s, "fwd_both");

        // mult/div latency with mflo waiting in decode
        s = z; s.mdstartE = 1;
        runCycle(s, "md_c0");
        s = z; s.hiloreadD = 1;
        for (int i = 1; i <= 5; i++) runCycle(s, $sformatf("mflo_c%0d", i));

        // back-to-back mult reload from DONE
        s = z; s.mdstartE = 1;
        runCycle(s, "mult1");
        s = z; s.mdstartD = 1;
        for (int i = 0; i < 3; i++) runCycle(s, "mult2_wait");
        s = z; s.mdstartE = 1;
        runCycle(s, "mult2_issue");
        for (int i = 0; i < 5; i++) runCycle(z, "mult2_busy");

        // async reset mid-BUSY
        s = z; s.mdstartE = 1;
        runCycle(s, "rst_start");
        runCycle(z, "rst_busy");
        #2;
        rstn = 1'b0;
        #1;
        checkVal("rst_async", dutOut(), 6'b000000);
        remain = 0;
        #1;
        rstn = 1'b1;
        runCycle(z, "rst_idle");
        s = z; s.mdstartE = 1;
        runCycle(s, "rst_restart");
        for (int i = 0; i < 5; i++) runCycle(z, "rst_lat");

        // random traffic with every hit term suppressed
        for (int n = 0; n < 10000; n++) begin
            s = stim_t'({$urandom, $urandom});
            s.mdstartE = 0;
            s.mdstartD = 0;
            if (h(s.rsD, s.writeregE) || h(s.rtD, s.writeregE)) s.writeregE = 5'd0;
            if (h(s.rsD, s.writeregM) || h(s.rtD, s.writeregM)) s.writeregM = 5'd0;
            runCycle(s, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
